// File: rtl/xor_checksum.sv
// Frame XOR checksum: accumulates words of a frame and presents the XOR, word count and overflow flag.
// Optional macro XOR_CHECKSUM_PARITY_EN adds out_parity, the reduction-XOR of out_data.
module xor_checksum #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    word_count,
    output logic             busy,
`ifdef XOR_CHECKSUM_PARITY_EN
    output logic             out_parity,
`endif
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             xfer;

    // in_ready depends on state only, so in_valid never feeds back into it.
    assign xfer = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    acc_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d   = acc_q ^ in_data;
                    count_d = count_q + CW'(1);
                    if (in_last) begin
                        state_d = DONE;
                    end else if (count_q == CW'(MAX_WORDS - 1)) begin
                        state_d    = DONE;
                        overflow_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef XOR_CHECKSUM_PARITY_EN
    logic parity_q, parity_d;

    // Parity tracks the next accumulator value so it updates on the same edge as out_data.
    always_comb begin
        parity_d = ^acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_data   = acc_q;
    assign word_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_xor_checksum.sv
// Self-checking bench for xor_checksum: directed frames plus randomized traffic against a queue-based frame model.
module tb_xor_checksum;

    localparam int WIDTH = 8;
    localparam int MAXW  = 4;
    localparam int CW    = $clog2(MAXW + 1);

    localparam int M_IDLE  = 0;
    localparam int M_ACCUM = 1;
    localparam int M_DONE  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    word_count;
    logic             busy;
    logic             overflow;
`ifdef XOR_CHECKSUM_PARITY_EN
    logic             out_parity;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int frames   = 0;

    // Frame-level model: the list of words accepted in the current/last frame.
    int               m_mode = M_IDLE;
    logic [WIDTH-1:0] m_words[$];
    logic             m_ovf = 1'b0;

    xor_checksum #(.WIDTH(WIDTH), .MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_count(word_count),
        .busy      (busy),
`ifdef XOR_CHECKSUM_PARITY_EN
        .out_parity(out_parity),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] frame_xor();
        logic [WIDTH-1:0] x = '0;
        foreach (m_words[i]) x = x ^ m_words[i];
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Model update.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_words.delete();
            m_ovf = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_words.delete();
                    m_ovf  = 1'b0;
                    m_mode = M_ACCUM;
                end
                M_ACCUM: if (in_valid) begin
                    m_words.push_back(in_data);
                    if (in_last) m_mode = M_DONE;
                    else if (m_words.size() == MAXW) begin
                        m_mode = M_DONE;
                        m_ovf  = 1'b1;
                    end
                    if (m_mode == M_DONE) begin
                        frames++;
                        $display("frame %0d: words=%0d xor=%02h overflow=%0b",
                                 frames, m_words.size(), frame_xor(), m_ovf);
                    end
                end
                M_DONE: if (out_ready) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("in_ready",   in_ready,   m_mode == M_ACCUM);
        chk("out_valid",  out_valid,  m_mode == M_DONE);
        chk("busy",       busy,       m_mode != M_IDLE);
        chk("out_data",   out_data,   frame_xor());
        chk("word_count", word_count, m_words.size());
        chk("overflow",   overflow,   m_ovf);
`ifdef XOR_CHECKSUM_PARITY_EN
        chk("out_parity", out_parity, ^frame_xor());
`endif
    end

    initial begin
        // Reset holds everything at zero even before any clock edge.
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_out_data",  out_data,  0);
        repeat (3) cyc();
        rst_n = 1'b1;

        // Idle ignores in_valid.
        in_valid = 1'b1;
        in_data  = 8'h77;
        cyc();
        cyc();
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_data", out_data, 8'h00);
        in_valid = 1'b0;

        // A5 ^ 3C ^ FF = 66, three words, no overflow.
        pulse_start();
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b0);
        chk("f1_not_yet_valid", out_valid, 0);
        send(8'hFF, 1'b1);
        chk("f1_out_valid",  out_valid,  1);
        chk("f1_out_data",   out_data,   8'h66);
        chk("f1_word_count", word_count, 3);
        chk("f1_overflow",   overflow,   0);
`ifdef XOR_CHECKSUM_PARITY_EN
        chk("f1_parity",     out_parity, 0);
`endif

        // Backpressure in DONE, with a start pulse that must be ignored.
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            cyc();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data",  out_data,  8'h66);
        end
        start = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_back_idle",  busy,       0);
        chk("bp_retained",   out_data,   8'h66);
        chk("bp_count_kept", word_count, 3);

        // Four words with no in_last reach MAX_WORDS and flag overflow.
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        send(8'h08, 1'b0);
        chk("ov_out_valid",  out_valid,  1);
        chk("ov_out_data",   out_data,   8'h0F);
        chk("ov_word_count", word_count, 4);
        chk("ov_overflow",   overflow,   1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Gapped input: the invalid cycle's data is not absorbed.
        pulse_start();
        send(8'h10, 1'b0);
        in_data = WIDTH'($urandom);
        cyc();
        send(8'h01, 1'b1);
        chk("gap_out_data",   out_data,   8'h11);
        chk("gap_word_count", word_count, 2);
        chk("gap_overflow",   overflow,   0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Reset mid-frame clears outputs without waiting for a clock edge.
        pulse_start();
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_data",  out_data,   0);
        chk("mid_rst_count",     word_count, 0);
        chk("mid_rst_in_ready",  in_ready,   0);
        chk("mid_rst_busy",      busy,       0);
        cyc();
        rst_n = 1'b1;
        pulse_start();
        send(8'h55, 1'b1);
        chk("post_rst_out_data", out_data,   8'h55);
        chk("post_rst_count",    word_count, 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = WIDTH'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 79) != 0);
            cyc();
        end
        rst_n     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter MAX_WORDS, default 16, giving the maximum words per frame (legal range 2..1024).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle request to open a new frame.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the input word is valid.
REQ-007 The block SHALL have port in_data, input, WIDTH bits, the input word.
REQ-008 The block SHALL have port in_last, input, 1 bit, marking the last word of the frame, qualified by the transfer.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the checksum result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits, the XOR of all accepted words of the frame.
REQ-013 The block SHALL have port word_count, output, $clog2(MAX_WORDS+1) bits, the number of words accepted in the current or last frame.
REQ-014 The block SHALL have port busy, output, 1 bit, high in ACCUM or DONE.
REQ-015 The block SHALL have port overflow, output, 1 bit, sticky per frame: MAX_WORDS words were accepted without in_last.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 SHALL move the FSM to ACCUM on the next edge and clear the accumulator, word_count and overflow on that same edge.
REQ-018 In IDLE, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-019 In ACCUM, in_ready SHALL be 1; a transfer is in_valid & in_ready, with no combinational path from in_valid to in_ready.
REQ-020 On each transfer: acc <= acc ^ in_data; word_count <= word_count + 1.
REQ-021 A transfer with in_last=1 SHALL move the FSM to DONE on the same edge.
REQ-022 A transfer without in_last that makes word_count equal MAX_WORDS SHALL move the FSM to DONE and set overflow=1.
REQ-023 If in_last=1 coincides with the MAX_WORDS-th word, overflow SHALL remain 0.
REQ-024 In DONE, out_valid SHALL be 1, in_ready SHALL be 0, and out_data and word_count SHALL hold stable until handshake.
REQ-025 out_valid & out_ready SHALL return the FSM to IDLE on the next edge; out_data, word_count and overflow SHALL retain their values until the next start.
REQ-026 Result latency SHALL be one cycle: out_valid rises on the edge that captures the final transfer.
REQ-027 start SHALL be ignored in ACCUM and DONE, with no abort and no restart.
REQ-028 A zero-word frame is impossible; frames end only via in_last or MAX_WORDS.
REQ-029 out_valid SHALL be 0 outside DONE.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with in_ready, out_valid, busy and overflow at 0, and out_data and word_count all zeros, regardless of clk.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame immediately; the first edge after deassertion SHALL behave as IDLE.

Configuration
REQ-032 With macro XOR_CHECKSUM_PARITY_EN defined, the block SHALL add output out_parity, 1 bit, equal to the reduction-XOR of out_data, registered with and valid alongside out_data.
REQ-033 Without XOR_CHECKSUM_PARITY_EN, port out_parity and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover reset then idle: in_valid=1 in IDLE -> in_ready=0 and out_data stays 8'h00.
REQ-035 The bench SHALL cover WIDTH=8: start, then words 8'hA5, 8'h3C, 8'hFF (last) -> out_valid the cycle after the third word, out_data=8'h66, word_count=3, overflow=0, out_parity=0.
REQ-036 The bench SHALL cover MAX_WORDS=4 with four words 8'h01, 8'h02, 8'h04, 8'h08 and no in_last -> DONE, out_data=8'h0F, word_count=4, overflow=1.
REQ-037 The bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held and out_data stable; a start pulse in DONE is ignored; out_ready=1 -> IDLE next cycle.
REQ-038 The bench SHALL cover gapped input: in_valid toggled 1,0,1(last) with data 8'h10, 8'hXX, 8'h01 -> out_data=8'h11, word_count=2.
REQ-039 The bench SHALL cover reset after two transfers -> all outputs 0 asynchronously; a new frame 8'h55 (last) -> out_data=8'h55, word_count=1.
